// File: rtl/gcm_job_ctrl_if.sv
// Request, core and response signal bundle for gcm_job_ctrl.
// slave:  the job controller itself.
// master: the environment, which holds the requesters, the core and the response sink.
interface gcm_job_ctrl_if;
    logic [1:0]   i_req_valid;
    logic [1:0]   o_req_ready;
    logic [0:479] i_req0_sw;
    logic [0:479] i_req1_sw;

    logic         o_core_new_instance;
    logic [0:95]  o_core_iv;
    logic [0:127] o_core_plain_text;
    logic [0:127] o_core_key;
    logic [0:127] o_core_aad;
    logic         i_core_cp_ready;
    logic [0:127] i_core_cipher_text;
    logic         i_core_tag_ready;
    logic [0:127] i_core_tag;

    logic         o_rsp_valid;
    logic         i_rsp_ready;
    logic         o_rsp_id;
    logic [0:127] o_rsp_cipher_text;
    logic [0:127] o_rsp_tag;
    logic         o_rsp_timeout;
    logic         o_busy;

    modport slave (
        input  i_req_valid, i_req0_sw, i_req1_sw,
        input  i_core_cp_ready, i_core_cipher_text, i_core_tag_ready, i_core_tag,
        input  i_rsp_ready,
        output o_req_ready,
        output o_core_new_instance, o_core_iv, o_core_plain_text, o_core_key, o_core_aad,
        output o_rsp_valid, o_rsp_id, o_rsp_cipher_text, o_rsp_tag, o_rsp_timeout,
        output o_busy
    );

    modport master (
        output i_req_valid, i_req0_sw, i_req1_sw,
        output i_core_cp_ready, i_core_cipher_text, i_core_tag_ready, i_core_tag,
        output i_rsp_ready,
        input  o_req_ready,
        input  o_core_new_instance, o_core_iv, o_core_plain_text, o_core_key, o_core_aad,
        input  o_rsp_valid, o_rsp_id, o_rsp_cipher_text, o_rsp_tag, o_rsp_timeout,
        input  o_busy
    );
endinterface

// File: rtl/gcm_job_ctrl.sv
// gcm_job_ctrl: two-requester round-robin job controller in front of a gcm_aes core.
// A granted job is registered onto the core inputs, started with a new-instance
// pulse, and its ciphertext/tag are returned on a valid/ready response channel.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | arbitrate requesters, register payload of the winner
// LOAD     | new-instance pulse high for NEW_PULSE_CYCLES cycles
// WAIT_CT  | wait for ciphertext; a tag arriving with it is taken too
// WAIT_TAG | ciphertext held, wait for tag
// RESP     | response valid, fields held until accepted
module gcm_job_ctrl #(
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int NEW_PULSE_CYCLES = 1
) (
    input logic           clk,
    input logic           i_reset_n,
    gcm_job_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_CT  = 3'd2,
        ST_WAIT_TAG = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  PULSE_LAST = 4'(NEW_PULSE_CYCLES - 1);

    state_t       state_q, state_d;
    logic         last_grant_q;
    logic         rsp_id_q;
    logic [3:0]   pulse_cnt_q;
    logic [15:0]  to_cnt_q;
    logic [0:95]  iv_q;
    logic [0:127] pt_q;
    logic [0:127] key_q;
    logic [0:127] aad_q;
    logic [0:127] ct_q;
    logic [0:127] tag_q;
    logic         timeout_q;

    logic [1:0]   grant;
    logic         grant_id;
    logic         accept;
    logic         cap_ct;
    logic         cap_tag;
    logic         set_to;
    logic         expire;
    logic [0:479] win_sw;

    assign expire = (to_cnt_q == TO_LAST);
    assign win_sw = grant_id ? bus.i_req1_sw : bus.i_req0_sw;

    // Arbitration, next state and capture strobes
    always_comb begin
        state_d  = state_q;
        grant    = 2'b00;
        grant_id = 1'b0;
        accept   = 1'b0;
        cap_ct   = 1'b0;
        cap_tag  = 1'b0;
        set_to   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                case (bus.i_req_valid)
                    2'b01: begin
                        grant    = 2'b01;
                        grant_id = 1'b0;
                    end
                    2'b10: begin
                        grant    = 2'b10;
                        grant_id = 1'b1;
                    end
                    2'b11: begin
                        grant_id = ~last_grant_q;
                        grant    = last_grant_q ? 2'b01 : 2'b10;
                    end
                    default: begin
                        grant    = 2'b00;
                        grant_id = 1'b0;
                    end
                endcase
                if (grant != 2'b00) begin
                    accept  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (pulse_cnt_q == 4'd0) begin
                    state_d = ST_WAIT_CT;
                end
            end
            ST_WAIT_CT: begin
                // a finished job beats an expiry landing on the same cycle
                if (bus.i_core_cp_ready && bus.i_core_tag_ready) begin
                    cap_ct  = 1'b1;
                    cap_tag = 1'b1;
                    state_d = ST_RESP;
                end else if (expire) begin
                    set_to  = 1'b1;
                    state_d = ST_RESP;
                end else if (bus.i_core_cp_ready) begin
                    cap_ct  = 1'b1;
                    state_d = ST_WAIT_TAG;
                end
            end
            ST_WAIT_TAG: begin
                if (bus.i_core_tag_ready) begin
                    cap_tag = 1'b1;
                    state_d = ST_RESP;
                end else if (expire) begin
                    set_to  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, round-robin pointer and the pulse/timeout counters
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            pulse_cnt_q  <= 4'd0;
            to_cnt_q     <= 16'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= grant_id;
                rsp_id_q     <= grant_id;
                pulse_cnt_q  <= PULSE_LAST;
            end else if (state_q == ST_LOAD && pulse_cnt_q != 4'd0) begin
                pulse_cnt_q <= pulse_cnt_q - 4'd1;
            end
            if (state_q == ST_LOAD) begin
                to_cnt_q <= 16'd0;
            end else if (state_q == ST_WAIT_CT || state_q == ST_WAIT_TAG) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
        end
    end

    // Core input registers and response capture
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            iv_q      <= '0;
            pt_q      <= '0;
            key_q     <= '0;
            aad_q     <= '0;
            ct_q      <= '0;
            tag_q     <= '0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            iv_q      <= win_sw[0   +: 96];
            pt_q      <= win_sw[96  +: 128];
            key_q     <= win_sw[224 +: 128];
            aad_q     <= win_sw[352 +: 128];
            ct_q      <= '0;
            tag_q     <= '0;
            timeout_q <= 1'b0;
        end else if (set_to) begin
            // an aborted job never returns partial results
            ct_q      <= '0;
            tag_q     <= '0;
            timeout_q <= 1'b1;
        end else begin
            if (cap_ct) begin
                ct_q <= bus.i_core_cipher_text;
            end
            if (cap_tag) begin
                tag_q <= bus.i_core_tag;
            end
        end
    end

    // ready is forced low while reset is held so no grant is seen during reset
    assign bus.o_req_ready         = grant & {2{i_reset_n}};
    assign bus.o_core_new_instance = (state_q == ST_LOAD);
    assign bus.o_core_iv           = iv_q;
    assign bus.o_core_plain_text   = pt_q;
    assign bus.o_core_key          = key_q;
    assign bus.o_core_aad          = aad_q;
    assign bus.o_rsp_valid         = (state_q == ST_RESP);
    assign bus.o_rsp_id            = rsp_id_q;
    assign bus.o_rsp_cipher_text   = ct_q;
    assign bus.o_rsp_tag           = tag_q;
    assign bus.o_rsp_timeout       = timeout_q;
    assign bus.o_busy              = (state_q != ST_IDLE);
endmodule

// File: tb/tb_gcm_job_ctrl.sv
// Bench for gcm_job_ctrl: two instances (default timing, and short timeout with
// a 3-cycle pulse) share one stimulus set; sel picks which one is driven and observed.
module tb_gcm_job_ctrl;
    localparam int TO_C [2] = '{1024, 8};
    localparam int NP_C [2] = '{1, 3};

    logic clk = 1'b0;
    logic rst_n;
    bit   sel;
    int   checks;
    int   errors;
    bit   lg [2];
    logic [1:0] pend;

    logic [1:0]   drv_valid;
    logic [0:479] drv_sw0, drv_sw1;
    logic         drv_cp, drv_tg, drv_rsp_ready;
    logic [0:127] drv_ct, drv_tag;

    logic [1:0]   obs_req_ready;
    logic         obs_new, obs_rsp_valid, obs_rsp_id, obs_timeout, obs_busy;
    logic [0:95]  obs_iv;
    logic [0:127] obs_pt, obs_key, obs_aad, obs_ct, obs_tag;

    always #5 clk = ~clk;

    gcm_job_ctrl_if ifa ();
    gcm_job_ctrl_if ifb ();

    gcm_job_ctrl #(.TIMEOUT_CYCLES(1024), .NEW_PULSE_CYCLES(1)) u_dut_a (
        .clk(clk), .i_reset_n(rst_n), .bus(ifa)
    );
    gcm_job_ctrl #(.TIMEOUT_CYCLES(8), .NEW_PULSE_CYCLES(3)) u_dut_b (
        .clk(clk), .i_reset_n(rst_n), .bus(ifb)
    );

    assign ifa.i_req_valid        = sel ? 2'b00 : drv_valid;
    assign ifb.i_req_valid        = sel ? drv_valid : 2'b00;
    assign ifa.i_core_cp_ready    = sel ? 1'b0 : drv_cp;
    assign ifb.i_core_cp_ready    = sel ? drv_cp : 1'b0;
    assign ifa.i_core_tag_ready   = sel ? 1'b0 : drv_tg;
    assign ifb.i_core_tag_ready   = sel ? drv_tg : 1'b0;
    assign ifa.i_rsp_ready        = sel ? 1'b0 : drv_rsp_ready;
    assign ifb.i_rsp_ready        = sel ? drv_rsp_ready : 1'b0;
    assign ifa.i_req0_sw          = drv_sw0;
    assign ifb.i_req0_sw          = drv_sw0;
    assign ifa.i_req1_sw          = drv_sw1;
    assign ifb.i_req1_sw          = drv_sw1;
    assign ifa.i_core_cipher_text = drv_ct;
    assign ifb.i_core_cipher_text = drv_ct;
    assign ifa.i_core_tag         = drv_tag;
    assign ifb.i_core_tag         = drv_tag;

    assign obs_req_ready = sel ? ifb.o_req_ready         : ifa.o_req_ready;
    assign obs_new       = sel ? ifb.o_core_new_instance : ifa.o_core_new_instance;
    assign obs_iv        = sel ? ifb.o_core_iv           : ifa.o_core_iv;
    assign obs_pt        = sel ? ifb.o_core_plain_text   : ifa.o_core_plain_text;
    assign obs_key       = sel ? ifb.o_core_key          : ifa.o_core_key;
    assign obs_aad       = sel ? ifb.o_core_aad          : ifa.o_core_aad;
    assign obs_rsp_valid = sel ? ifb.o_rsp_valid         : ifa.o_rsp_valid;
    assign obs_rsp_id    = sel ? ifb.o_rsp_id            : ifa.o_rsp_id;
    assign obs_ct        = sel ? ifb.o_rsp_cipher_text   : ifa.o_rsp_cipher_text;
    assign obs_tag       = sel ? ifb.o_rsp_tag           : ifa.o_rsp_tag;
    assign obs_timeout   = sel ? ifb.o_rsp_timeout       : ifa.o_rsp_timeout;
    assign obs_busy      = sel ? ifb.o_busy              : ifa.o_busy;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
        end
    endtask

    function automatic logic [0:479] rand_payload();
        logic [0:479] p;
        for (int i = 0; i < 15; i++) p[i*32 +: 32] = $urandom();
        return p;
    endfunction

    function automatic logic [0:127] rand128();
        logic [0:127] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, obs_req_ready, 0);
        chk({tag, "_new"},       obs_new, 0);
        chk({tag, "_iv"},        obs_iv, 0);
        chk({tag, "_pt"},        obs_pt, 0);
        chk({tag, "_key"},       obs_key, 0);
        chk({tag, "_aad"},       obs_aad, 0);
        chk({tag, "_rsp_valid"}, obs_rsp_valid, 0);
        chk({tag, "_rsp_id"},    obs_rsp_id, 0);
        chk({tag, "_ct"},        obs_ct, 0);
        chk({tag, "_tag"},       obs_tag, 0);
        chk({tag, "_timeout"},   obs_timeout, 0);
        chk({tag, "_busy"},      obs_busy, 0);
    endtask

    // One job: called at an IDLE-cycle negedge, returns at the following IDLE-cycle negedge.
    // dcp/dtag: cycles after WAIT_CT entry at which the core raises each ready (held high).
    task automatic do_job(input logic [1:0] req, input int dcp, input int dtag,
                          input int bp, input bit stale);
        logic [1:0]   valid, g;
        logic         gid;
        logic [0:479] p;
        logic [0:127] ct, tg;
        int           c, rk, cnt, t_lim;
        bit           to;

        valid     = req | pend;
        drv_valid = valid;
        #1;
        if (valid == 2'b11) gid = ~lg[sel];
        else                gid = valid[1];
        g = gid ? 2'b10 : 2'b01;
        chk("grant", obs_req_ready, g);
        chk("idle_busy", obs_busy, 0);
        p = gid ? drv_sw1 : drv_sw0;
        @(posedge clk);
        lg[sel] = gid;
        pend    = valid & ~g;
        #1;
        drv_valid = pend;
        if (gid) drv_sw1 = rand_payload();
        else     drv_sw0 = rand_payload();

        ct = rand128();
        tg = rand128();
        if (stale) begin
            drv_cp  = 1'b1;
            drv_tg  = 1'b1;
            drv_ct  = ~ct;
            drv_tag = ~tg;
        end
        @(negedge clk);
        cnt = 0;
        while (obs_new === 1'b1 && cnt < 20) begin
            if (cnt == 0) begin
                chk("core_iv",  obs_iv,  p[0 +: 96]);
                chk("core_pt",  obs_pt,  p[96 +: 128]);
                chk("core_key", obs_key, p[224 +: 128]);
                chk("core_aad", obs_aad, p[352 +: 128]);
                chk("load_busy", obs_busy, 1);
            end
            chk("load_req_ready", obs_req_ready, 0);
            cnt++;
            @(negedge clk);
        end
        chk("pulse_len", cnt, NP_C[sel]);

        t_lim = TO_C[sel];
        c     = (dcp > dtag) ? dcp : dtag;
        if (c <= t_lim - 1) begin
            rk = c + 1;
            to = 1'b0;
        end else begin
            rk = t_lim;
            to = 1'b1;
        end
        for (int k = 0; k < rk; k++) begin
            drv_cp  = (k >= dcp);
            drv_tg  = (k >= dtag);
            drv_ct  = ct;
            drv_tag = tg;
            #1;
            chk("wait_rsp_valid", obs_rsp_valid, 0);
            chk("wait_req_ready", obs_req_ready, 0);
            @(negedge clk);
        end
        drv_cp = 1'b0;
        drv_tg = 1'b0;

        for (int b = 0; b <= bp; b++) begin
            chk("rsp_valid",   obs_rsp_valid, 1);
            chk("rsp_id",      obs_rsp_id, gid);
            chk("rsp_ct",      obs_ct, to ? 128'h0 : ct);
            chk("rsp_tag",     obs_tag, to ? 128'h0 : tg);
            chk("rsp_timeout", obs_timeout, to);
            chk("rsp_req_ready", obs_req_ready, 0);
            if (b == 0) chk("rsp_core_key_hold", obs_key, p[224 +: 128]);
            if (b == bp) drv_rsp_ready = 1'b1;
            @(negedge clk);
        end
        drv_rsp_ready = 1'b0;
        #1;
        chk("post_rsp_valid", obs_rsp_valid, 0);
        chk("post_busy", obs_busy, 0);
    endtask

    task automatic flush_pending();
        if (pend != 2'b00) do_job(pend, 1, 2, 0, 0);
        drv_valid = 2'b00;
    endtask

    initial begin
        int a, b2;
        checks = 0; errors = 0; sel = 1'b0; pend = 2'b00;
        rst_n = 1'b0;
        drv_valid = 2'b11; drv_cp = 1'b0; drv_tg = 1'b0; drv_rsp_ready = 1'b0;
        drv_ct = '0; drv_tag = '0;
        drv_sw0 = rand_payload(); drv_sw1 = rand_payload();
        lg[0] = 1'b1; lg[1] = 1'b1;

        #12;
        sel = 1'b0; #1 chk_zero("rst_a");
        sel = 1'b1; #1 chk_zero("rst_b");
        sel = 1'b0;
        drv_valid = 2'b00;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // contention: both requesters keep asking
        for (int j = 0; j < 4; j++) begin
            a  = $urandom_range(0, 6);
            b2 = a + $urandom_range(0, 6);
            do_job(2'b11, a, b2, 0, 0);
        end
        // single req0 job with split readies
        do_job(2'b01, 12, 20, 0, 0);
        // simultaneous readies and 5 cycles of response backpressure
        do_job(2'b01, 7, 7, 5, 0);
        // randomized jobs
        for (int j = 0; j < 12; j++) begin
            a  = $urandom_range(0, 15);
            b2 = a + $urandom_range(0, 15);
            do_job(2'($urandom_range(1, 3)), a, b2, $urandom_range(0, 3), 0);
        end
        flush_pending();

        // short-timeout instance
        sel = 1'b1;
        do_job(2'b01, 2, 1000, 0, 0);
        do_job(2'b10, 0, 0, 1, 1);
        do_job(2'b01, 3, 7, 0, 0);
        do_job(2'b10, 3, 8, 2, 0);
        for (int j = 0; j < 10; j++) begin
            do_job(2'($urandom_range(1, 3)), $urandom_range(0, 9), $urandom_range(0, 12),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        flush_pending();

        // reset in the middle of a job (default instance)
        sel = 1'b0;
        drv_valid = 2'b01;
        #1;
        @(posedge clk);
        #1;
        drv_valid = 2'b00;
        drv_sw0 = rand_payload();
        repeat (3) @(negedge clk);
        drv_cp = 1'b1;
        @(negedge clk);
        drv_cp = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", obs_busy, 1);
        chk("pre_rst_rsp_valid", obs_rsp_valid, 0);
        drv_valid = 2'b11;
        #2 rst_n = 1'b0;
        lg[0] = 1'b1; lg[1] = 1'b1;
        #1 chk_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        drv_valid = 2'b00;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("after_rst_rsp_valid", obs_rsp_valid, 0);
            chk("after_rst_busy", obs_busy, 0);
        end
        do_job(2'b10, 4, 9, 1, 0);
        drv_valid = 2'b00;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gcm_job_ctrl.md
# gcm_job_ctrl

Job controller for the `gcm_aes` core. It arbitrates single-block GCM encryption jobs from two requesters with round-robin priority. For each granted job it loads IV, key, AAD and plaintext into the core, pulses the core's new-instance input, and collects the ciphertext and tag. It returns them on a valid/ready response channel with requester ID and a timeout flag. It sits between the `aes` top-level input bus and the `gcm_aes` instance.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum cycles spent in WAIT_CT plus WAIT_TAG before the job is aborted.
- `NEW_PULSE_CYCLES`, default 1: width of the `o_core_new_instance` pulse in cycles (1..15).

Ports:
- `clk` in 1: single clock, which is also the core clock.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_req_valid` in 2: per-requester job valid.
- `o_req_ready` in 2 / out 2: per-requester accept. Direction is out.
- `i_req0_sw`, `i_req1_sw` in [0:479] each: job payload. Bits 0+:96 are IV, 96+:128 are plaintext, 224+:128 are key, 352+:128 are AAD.
- `o_core_new_instance` out 1: new-instance pulse to the core.
- `o_core_iv` out [0:95]: registered IV to the core.
- `o_core_plain_text` out [0:127]: registered plaintext to the core.
- `o_core_key` out [0:127]: registered key to the core.
- `o_core_aad` out [0:127]: registered AAD to the core.
- `i_core_cp_ready` in 1: core ciphertext ready.
- `i_core_cipher_text` in [0:127]: core ciphertext.
- `i_core_tag_ready` in 1: core tag ready.
- `i_core_tag` in [0:127]: core tag.
- `o_rsp_valid` out 1: response valid.
- `i_rsp_ready` in 1: response accept.
- `o_rsp_id` out 1: requester index of the response.
- `o_rsp_cipher_text` out [0:127]: response ciphertext.
- `o_rsp_tag` out [0:127]: response tag.
- `o_rsp_timeout` out 1: set when the job timed out.
- `o_busy` out 1: high in any state except IDLE.

## Operation

States: IDLE, LOAD, WAIT_CT, WAIT_TAG, RESP.

- **IDLE**
  - `o_req_ready[g]` = 1 only for the arbiter winner g. It is combinational from `i_req_valid` and the priority pointer. The other bit is 0.
  - Winner: if exactly one requester is valid, grant it. If both are valid, grant the one not equal to `last_grant`.
  - On handshake:
    - Register the payload into the `o_core_*` data outputs.
    - Record the ID and set `last_grant` = g.
    - Clear the capture registers and the timeout flag.
    - Go to LOAD.
- **LOAD**
  - `o_core_new_instance` = 1 for `NEW_PULSE_CYCLES` cycles, counted by a pulse counter.
  - Then go to WAIT_CT with the timeout counter at 0.
  - Core contract: the core deasserts its ready outputs while new-instance is high.
- **WAIT_CT**
  - On the first cycle with `i_core_cp_ready` = 1, capture `i_core_cipher_text`.
  - If `i_core_tag_ready` is also 1 in that cycle, capture `i_core_tag` too and go directly to RESP. Otherwise go to WAIT_TAG.
  - A `tag_ready` without `cp_ready` in WAIT_CT is ignored.
- **WAIT_TAG**
  - On `i_core_tag_ready` = 1, capture `i_core_tag` and go to RESP.
- **Timeout**
  - A 16-bit counter increments every cycle in WAIT_CT and WAIT_TAG.
  - When the counter equals `TIMEOUT_CYCLES`−1 without completion:
    - Go to RESP with `o_rsp_timeout` = 1.
    - Ciphertext and tag are forced to 0, including any ciphertext already captured.
  - Completion wins if it occurs in the same cycle as expiry.
- **RESP**
  - `o_rsp_valid` = 1. All response fields hold stable until `i_rsp_ready` = 1.
  - After the handshake cycle, go to IDLE.
  - No new request is accepted while in RESP.
- Core data outputs hold their value from LOAD until the next IDLE grant.

## Timing

- **Reset** (`i_reset_n` low, asynchronous, from any state):
  - State = IDLE, `last_grant` = 1, so requester 0 wins first contention.
  - All outputs are 0: `o_core_*`, `o_rsp_*`, `o_busy`.
  - `o_req_ready` = 0 for that cycle.
  - Reset mid-job abandons the job. No response is produced.
- **Grant:** `o_req_ready` is valid in the same cycle as `i_req_valid` in IDLE. A request accepted at edge N has `o_core_new_instance` high from cycle N+1 to N+`NEW_PULSE_CYCLES`.
- **Ready sampling:** core readies are sampled only from WAIT_CT entry onward. Stale readies during LOAD are ignored.
- **Response latency:** the response is valid the cycle after the capturing edge.
- **Back-to-back jobs:** minimum spacing between jobs is 1 idle cycle after the response handshake.
- **Requester hold:** a requester holding valid keeps its payload stable until ready.

## Test plan

- **Single job, split readies.** Only req0 valid; core model raises `cp_ready` 12 cycles and `tag_ready` 20 cycles after the pulse ends.
  - Required: one-cycle `new_instance`, `rsp_valid` with `id`=0, expected ciphertext/tag, `timeout`=0.
- **Contention and round-robin.** Both requesters valid continuously for 4 jobs.
  - Required: grant order 0,1,0,1; each response ID matches its grant.
- **Simultaneous readies and backpressure.** `cp_ready` and `tag_ready` rise in the same cycle; hold `rsp_ready`=0 for 5 cycles.
  - Required: direct WAIT_CT→RESP; response fields stable for all 5 cycles; single handshake; `o_req_ready` stays 0 until back in IDLE.
- **Timeout.** `TIMEOUT_CYCLES`=8; core never raises `tag_ready` after `cp_ready`.
  - Required: RESP entered exactly 8 cycles after WAIT_CT entry; `timeout`=1; ciphertext and tag are 0.
- **Stale ready.** `NEW_PULSE_CYCLES`=3; core holds `cp_ready` high during LOAD from the previous job.
  - Required: capture happens only after WAIT_CT entry.
- **Reset mid-job.** Drop `i_reset_n` while in WAIT_TAG.
  - Required: all outputs 0 immediately; after release, a new req1 job completes normally; no response for the aborted job.
